pipe_stall_ctrl: RTL

Central stall/flush controller for the seven-stage integer pipeline (PC, IF, ID, EX, DC, MEM, WB). It merges per-stage stall requests into the shared `StallBus` vector that every inter-stage register consumes. It sequences exception flushes and redirects the PC. It also keeps stall-cycle statistics and a stuck-stall watchdog for debug.

---
 rtl/pipe_stall_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_stall_ctrl                                            |
// | Description : Stall-vector merge, exception flush/redirect sequencing,   |
// |               stall-cycle statistics and stuck-stall watchdog.           |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module pipe_stall_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int TIMEOUT      = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_dc,
   input  logic        stallreq_mem,
   input  logic        excp_valid,
   input  logic [31:0] excp_pc,
   output logic [6:0]  stall,
   output logic        flush,
   output logic        new_pc_valid,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cycles,
   output logic        stall_timeout
);

   localparam logic [0:0] c_st_run   = 1'b0;
   localparam logic [0:0] c_st_flush = 1'b1;

   localparam logic [2:0] c_flush_last = 3'(FLUSH_CYCLES - 1);

   localparam int c_wd_bits = $clog2(TIMEOUT + 1);
   localparam int c_wd_w    = (c_wd_bits > 11) ? c_wd_bits : 11;
   localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);
   localparam logic [c_wd_w-1:0] c_wd_one  = c_wd_w'(1);

   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;
   logic [2:0]        r_flush_cnt;
   logic [31:0]       r_new_pc;
   logic [31:0]       r_stall_cycles;
   logic [c_wd_w-1:0] r_wd_cnt;
   logic              r_timeout;

   logic [6:0]        w_req;
   logic [6:0]        w_run_stall;
   logic [6:0]        w_stall;
   logic              w_flush;
   logic              w_npv;
   logic              w_any_req;
   logic              w_take;
   logic              w_first;

   // Request slot i asks stage i to hold; bit 6 (WB) never requests.
   assign w_req     = {1'b0, stallreq_mem, stallreq_dc, stallreq_ex,
                       stallreq_id, stallreq_if, 1'b0};
   assign w_any_req = |w_req;
   assign w_take    = (r_state == c_st_run) && excp_valid && !stallreq_mem;
   assign w_first   = (r_flush_cnt == c_flush_last);

   // A stage holds if it or any deeper stage requests, giving a vector
   // contiguous from bit 0.
   for (genvar i = 0; i < 7; i++) begin : g_stall
      assign w_run_stall[i] = |w_req[6:i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= c_st_run;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_run:   if (w_take) w_state_nxt = c_st_flush;
         c_st_flush: if (r_flush_cnt == 3'd0) w_state_nxt = c_st_run;
         default:    w_state_nxt = c_st_run;
      endcase
   end

   always_comb begin
      w_flush = 1'b0;
      w_npv   = 1'b0;
      w_stall = 7'b0;
      case (r_state)
         // A taken exception discards the shallower stalls of the same cycle.
         c_st_run:   w_stall = w_take ? 7'b0 : w_run_stall;
         c_st_flush: begin
            w_flush = 1'b1;
            w_npv   = w_first;
            w_stall = {6'b0, !w_first};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flush_cnt <= 3'd0;
         r_new_pc    <= 32'd0;
      end else if (w_take) begin
         r_flush_cnt <= c_flush_last;
         r_new_pc    <= excp_pc;
      end else if (r_state == c_st_flush && r_flush_cnt != 3'd0) begin
         r_flush_cnt <= r_flush_cnt - 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cycles <= 32'd0;
      end else if (w_stall[0] && r_stall_cycles != 32'hFFFF_FFFF) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wd_cnt  <= '0;
         r_timeout <= 1'b0;
      end else if (r_state == c_st_run && w_any_req) begin
         if (r_wd_cnt <= c_wd_last) r_wd_cnt <= r_wd_cnt + c_wd_one;
         if (r_wd_cnt == c_wd_last) r_timeout <= 1'b1;
      end else begin
         r_wd_cnt <= '0;
      end
   end

   assign stall         = rst ? 7'b0 : w_stall;
   assign flush         = w_flush;
   assign new_pc_valid  = w_npv;
   assign new_pc        = r_new_pc;
   assign stall_cycles  = r_stall_cycles;
   assign stall_timeout = r_timeout;

endmodule
`default_nettype wire
